// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_pkg
//  Description : Shared state encoding and BCD digit limits for the
//                countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_RING  = 2'b11
    } state_t;

    // Largest value a units / minutes-tens digit may hold.
    localparam int c_MAX_NINE = 9;
    // Largest value a seconds-tens digit may hold.
    localparam int c_MAX_FIVE = 5;

endpackage
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Control, preset and display bundle of the countdown timer.
//                master : drives Tick/LD/presets/Start/Stop, reads display
//                slave  : the timer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if;
    logic       Tick;
    logic       LD;
    logic [3:0] IN_MT;
    logic [3:0] IN_MU;
    logic [2:0] IN_ST;
    logic [3:0] IN_SU;
    logic       Start;
    logic       Stop;
    logic [3:0] MT;
    logic [3:0] MU;
    logic [2:0] ST;
    logic [3:0] SU;
    logic       Running;
    logic       Expired;
    logic       Buzz;

    modport master (
        output Tick, LD, IN_MT, IN_MU, IN_ST, IN_SU, Start, Stop,
        input  MT, MU, ST, SU, Running, Expired, Buzz
    );

    modport slave (
        input  Tick, LD, IN_MT, IN_MU, IN_ST, IN_SU, Start, Stop,
        output MT, MU, ST, SU, Running, Expired, Buzz
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : One down-counting digit with saturating load.
//                Clk/Clr : clock, async active-low reset
//                LD, IN  : load IN (clamped to MAX)
//                Dec     : borrow-in, decrement this digit
//                COUNT   : registered digit value
//                Borrow  : combinational borrow-out (COUNT==0 && Dec)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  wire logic         Clk,
    input  wire logic         Clr,
    input  wire logic         LD,
    input  wire logic [W-1:0] IN,
    input  wire logic         Dec,
    output logic      [W-1:0] COUNT,
    output logic              Borrow
);
    localparam logic [W-1:0] c_MAX = W'(MAX);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (LD) begin
            count_d = (IN > c_MAX) ? c_MAX : IN;
        end else if (Dec) begin
            count_d = (count_q == '0) ? c_MAX : count_q - W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT  = count_q;
    assign Borrow = Dec && (count_q == '0);
endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : MM:SS countdown timer with pause and timed alarm.
//                Clk  : system clock, rising edge
//                Clr  : async active-low reset
//                bus  : Tick/LD/presets/Start/Stop in, digits and
//                       Running/Expired/Buzz out (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int BUZZ_LEN = 10
) (
    input  wire logic           Clk,
    input  wire logic           Clr,
    countdown_timer_if.slave    bus
);
    localparam logic [7:0] c_BUZZ_LEN = 8'(BUZZ_LEN);

    state_t     state_d, state_q;
    logic [7:0] ring_d, ring_q;
    logic       running_d, running_q;
    logic       expired_d, expired_q;
    logic       buzz_d, buzz_q;

    logic       w_load;
    logic       w_dec;
    logic [3:0] w_mt, w_mu, w_su;
    logic [2:0] w_st;
    logic       w_su_borrow, w_st_borrow, w_mu_borrow;
    logic       w_mt_borrow_unused;
    logic       w_zero;
    logic       w_one;

    assign w_zero = (w_mt == 4'd0) && (w_mu == 4'd0) && (w_st == 3'd0) && (w_su == 4'd0);
    assign w_one  = (w_mt == 4'd0) && (w_mu == 4'd0) && (w_st == 3'd0) && (w_su == 4'd1);

    // Digit chain: seconds units borrows into tens, tens into minutes, etc.
    bcd_down_digit #(.W(4), .MAX(c_MAX_NINE)) u_su (
        .Clk(Clk), .Clr(Clr), .LD(w_load), .IN(bus.IN_SU),
        .Dec(w_dec), .COUNT(w_su), .Borrow(w_su_borrow));
    bcd_down_digit #(.W(3), .MAX(c_MAX_FIVE)) u_st (
        .Clk(Clk), .Clr(Clr), .LD(w_load), .IN(bus.IN_ST),
        .Dec(w_su_borrow), .COUNT(w_st), .Borrow(w_st_borrow));
    bcd_down_digit #(.W(4), .MAX(c_MAX_NINE)) u_mu (
        .Clk(Clk), .Clr(Clr), .LD(w_load), .IN(bus.IN_MU),
        .Dec(w_st_borrow), .COUNT(w_mu), .Borrow(w_mu_borrow));
    // The top digit never borrows: decrements are blocked at 00:00.
    bcd_down_digit #(.W(4), .MAX(c_MAX_NINE)) u_mt (
        .Clk(Clk), .Clr(Clr), .LD(w_load), .IN(bus.IN_MT),
        .Dec(w_mu_borrow), .COUNT(w_mt), .Borrow(w_mt_borrow_unused));

    always_comb begin
        state_d   = state_q;
        ring_d    = ring_q;
        expired_d = 1'b0;
        w_load    = 1'b0;
        w_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.LD) begin
                    w_load = 1'b1;
                end else if (bus.Start && !w_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stop beats a coincident Tick; that Tick is dropped.
                if (bus.Stop) begin
                    state_d = ST_PAUSE;
                end else if (bus.Tick && !w_zero) begin
                    w_dec = 1'b1;
                    if (w_one) begin
                        state_d   = ST_RING;
                        expired_d = 1'b1;
                        ring_d    = 8'd0;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.LD) begin
                    w_load  = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.Stop) begin
                    state_d = ST_IDLE;
                end else if (bus.Start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin // ST_RING
                if (bus.Stop) begin
                    state_d = ST_IDLE;
                    ring_d  = 8'd0;
                end else if (bus.Tick) begin
                    if (ring_q + 8'd1 >= c_BUZZ_LEN) begin
                        state_d = ST_IDLE;
                        ring_d  = 8'd0;
                    end else begin
                        ring_d = ring_q + 8'd1;
                    end
                end
            end
        endcase
        // Status flags are registered copies of the next state.
        running_d = (state_d == ST_RUN);
        buzz_d    = (state_d == ST_RING);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q   <= ST_IDLE;
            ring_q    <= 8'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            running_q <= running_d;
            expired_q <= expired_d;
            buzz_q    <= buzz_d;
        end
    end

    assign bus.MT      = w_mt;
    assign bus.MU      = w_mu;
    assign bus.ST      = w_st;
    assign bus.SU      = w_su;
    assign bus.Running = running_q;
    assign bus.Expired = expired_q;
    assign bus.Buzz    = buzz_q;
endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Directed self-checking bench for countdown_timer
//                (BUZZ_LEN = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;
    logic Clk;
    logic Clr;
    int   checks;
    int   errors;

    countdown_timer_if bus ();

    countdown_timer #(.BUZZ_LEN(3)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Display packed as 16'hMMSS (ST zero-extended to 4 bits).
    function automatic logic [15:0] disp();
        return {bus.MT, bus.MU, 1'b0, bus.ST, bus.SU};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_preset(input logic [3:0] mt, input logic [3:0] mu,
                              input logic [2:0] st, input logic [3:0] su);
        bus.IN_MT = mt;
        bus.IN_MU = mu;
        bus.IN_ST = st;
        bus.IN_SU = su;
    endtask

    task automatic pulse_ld();
        bus.LD = 1'b1;
        step();
        bus.LD = 1'b0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.Tick = 1'b1;
        step();
        bus.Tick = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clr       = 1'b0;
        bus.Tick  = 1'b0;
        bus.LD    = 1'b0;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        set_preset(4'd0, 4'd0, 3'd0, 4'd0);

        // Reset state
        #12;
        chk("reset_digits",  disp(),              16'h0000);
        chk("reset_running", 16'(bus.Running),    16'h0);
        chk("reset_expired", 16'(bus.Expired),    16'h0);
        chk("reset_buzz",    16'(bus.Buzz),       16'h0);
        Clr = 1'b1;
        step();
        chk("idle_after_clr", 16'(bus.Running),   16'h0);

        // 01:00 -> one tick -> 00:59
        set_preset(4'd0, 4'd1, 3'd0, 4'd0);
        pulse_ld();
        chk("load_0100", disp(), 16'h0100);
        pulse_start();
        chk("run_0100", 16'(bus.Running), 16'h1);
        pulse_tick();
        chk("tick_0059", disp(), 16'h0059);
        chk("tick_0059_running", 16'(bus.Running), 16'h1);

        // Pause then back to idle keeps the count
        pulse_stop();
        chk("pause_running", 16'(bus.Running), 16'h0);
        pulse_tick();
        chk("pause_hold", disp(), 16'h0059);
        pulse_stop();
        chk("idle_keep", disp(), 16'h0059);

        // 00:02 -> expiry and timed alarm
        set_preset(4'd0, 4'd0, 3'd0, 4'd2);
        pulse_ld();
        pulse_start();
        pulse_tick();
        chk("exp_0001", disp(), 16'h0001);
        chk("exp_not_yet", 16'(bus.Expired), 16'h0);
        pulse_tick();
        chk("exp_0000", disp(), 16'h0000);
        chk("exp_pulse", 16'(bus.Expired), 16'h1);
        chk("exp_buzz", 16'(bus.Buzz), 16'h1);
        chk("exp_not_running", 16'(bus.Running), 16'h0);
        step();
        chk("exp_one_clk", 16'(bus.Expired), 16'h0);
        chk("buzz_hold", 16'(bus.Buzz), 16'h1);
        pulse_tick();
        chk("buzz_t1", 16'(bus.Buzz), 16'h1);
        pulse_tick();
        chk("buzz_t2", 16'(bus.Buzz), 16'h1);
        pulse_tick();
        chk("buzz_t3_off", 16'(bus.Buzz), 16'h0);
        chk("ring_count_zero", disp(), 16'h0000);
        pulse_tick();
        chk("idle_tick_ignored", disp(), 16'h0000);
        pulse_start();
        chk("start_zero_idle", 16'(bus.Running), 16'h0);

        // 10:00 -> 09:59 (three-level borrow)
        set_preset(4'd1, 4'd0, 3'd0, 4'd0);
        pulse_ld();
        pulse_start();
        pulse_tick();
        chk("borrow_0959", disp(), 16'h0959);

        // 00:30, Stop+Tick together -> pause at 00:30
        pulse_stop();
        pulse_stop();
        set_preset(4'd0, 4'd0, 3'd3, 4'd0);
        pulse_ld();
        pulse_start();
        bus.Stop = 1'b1;
        bus.Tick = 1'b1;
        step();
        bus.Stop = 1'b0;
        bus.Tick = 1'b0;
        chk("stop_wins_count", disp(), 16'h0030);
        chk("stop_wins_pause", 16'(bus.Running), 16'h0);
        pulse_start();
        chk("resume_running", 16'(bus.Running), 16'h1);
        pulse_tick();
        chk("resume_0029", disp(), 16'h0029);

        // LD ignored in RUN
        set_preset(4'd0, 4'd5, 3'd0, 4'd5);
        pulse_ld();
        chk("run_ld_ignored", disp(), 16'h0029);

        // PAUSE: LD beats Stop and Start; out-of-range digits saturate
        pulse_stop();
        set_preset(4'd12, 4'd15, 3'd7, 4'd10);
        bus.LD = 1'b1;
        bus.Stop = 1'b1;
        bus.Start = 1'b1;
        step();
        bus.LD = 1'b0;
        bus.Stop = 1'b0;
        bus.Start = 1'b0;
        chk("sat_9959", disp(), 16'h9959);
        chk("pause_ld_idle", 16'(bus.Running), 16'h0);
        pulse_start();
        chk("idle_start_9959", 16'(bus.Running), 16'h1);
        pulse_stop();
        pulse_stop();

        // IDLE: LD and Start together -> load only
        set_preset(4'd0, 4'd0, 3'd0, 4'd0);
        bus.LD = 1'b1;
        bus.Start = 1'b1;
        step();
        bus.LD = 1'b0;
        bus.Start = 1'b0;
        chk("ld_start_load", disp(), 16'h0000);
        chk("ld_start_idle", 16'(bus.Running), 16'h0);
        pulse_start();
        chk("zero_start_idle", 16'(bus.Running), 16'h0);

        // Clr mid-RING aborts asynchronously
        set_preset(4'd0, 4'd0, 3'd0, 4'd1);
        pulse_ld();
        pulse_start();
        pulse_tick();
        chk("ring2_buzz", 16'(bus.Buzz), 16'h1);
        step();
        #2;
        Clr = 1'b0;
        #1;
        chk("clr_buzz_async", 16'(bus.Buzz), 16'h0);
        chk("clr_digits", disp(), 16'h0000);
        chk("clr_expired", 16'(bus.Expired), 16'h0);
        step();
        chk("clr_held_expired", 16'(bus.Expired), 16'h0);
        Clr = 1'b1;
        step();
        chk("post_clr_buzz", 16'(bus.Buzz), 16'h0);
        chk("post_clr_running", 16'(bus.Running), 16'h0);

        // Clr mid-RUN on the last second: no Expired pulse
        set_preset(4'd0, 4'd0, 3'd0, 4'd1);
        pulse_ld();
        pulse_start();
        bus.Tick = 1'b1;
        #2;
        Clr = 1'b0;
        step();
        bus.Tick = 1'b0;
        chk("clr_run_expired", 16'(bus.Expired), 16'h0);
        chk("clr_run_running", 16'(bus.Running), 16'h0);
        Clr = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter BUZZ_LEN, default 10: number of Tick pulses Buzz stays high after expiry (range 1..255).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port Clr, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port Tick, input, 1 bit: one-Clk-wide 1 Hz enable pulse.
REQ-005 The block SHALL have port LD, input, 1 bit: load preset digits, active high.
REQ-006 The block SHALL have port IN_MT, input, 4 bits: preset minutes tens, BCD 0-9.
REQ-007 The block SHALL have port IN_MU, input, 4 bits: preset minutes units, BCD 0-9.
REQ-008 The block SHALL have port IN_ST, input, 3 bits: preset seconds tens, 0-5.
REQ-009 The block SHALL have port IN_SU, input, 4 bits: preset seconds units, BCD 0-9.
REQ-010 The block SHALL have port Start, input, 1 bit: start or resume counting, level sampled each Clk.
REQ-011 The block SHALL have port Stop, input, 1 bit: pause, return to idle, or acknowledge the alarm.
REQ-012 The block SHALL have port MT, output, 4 bits: current minutes tens.
REQ-013 The block SHALL have port MU, output, 4 bits: current minutes units.
REQ-014 The block SHALL have port ST, output, 3 bits: current seconds tens.
REQ-015 The block SHALL have port SU, output, 4 bits: current seconds units.
REQ-016 The block SHALL have port Running, output, 1 bit: high in state RUN.
REQ-017 The block SHALL have port Expired, output, 1 bit: one-Clk pulse on reaching 00:00.
REQ-018 The block SHALL have port Buzz, output, 1 bit: high in state RING.

Function
REQ-019 The FSM SHALL have exactly four states, IDLE, RUN, PAUSE and RING; all outputs SHALL be registered.
REQ-020 In IDLE, LD SHALL load the digits on the next edge; any out-of-range digit SHALL saturate on load (units and minutes tens to 9, seconds tens to 5).
REQ-021 In IDLE, Start with a nonzero count SHALL go to RUN; Start with count 00:00 SHALL stay in IDLE.
REQ-022 In IDLE, LD and Start asserted together SHALL load and stay in IDLE, so LD wins.
REQ-023 In RUN, each Tick SHALL decrement the count by one second: SU 0 wraps to 9 with a borrow; ST 0 wraps to 5 with a borrow; MU 0 wraps to 9 with a borrow; MT is decremented by the borrow.
REQ-024 In RUN, a Tick that produces 00:00 SHALL enter RING and pulse Expired for exactly one Clk on the same edge.
REQ-025 In RUN, Stop SHALL go to PAUSE, and a Tick in the same cycle SHALL be discarded, so Stop wins.
REQ-026 In RUN, LD SHALL be ignored.
REQ-027 In PAUSE, the count SHALL be held.
REQ-028 In PAUSE, Start SHALL go to RUN and Stop SHALL go to IDLE, keeping the count.
REQ-029 In PAUSE, LD SHALL load the digits and go to IDLE, with priority LD > Stop > Start.
REQ-030 In RING, the count SHALL stay 00:00 and an 8-bit ring counter SHALL count Ticks.
REQ-031 In RING, after BUZZ_LEN Ticks the FSM SHALL go to IDLE; Stop SHALL go to IDLE at once.
REQ-032 In RING, LD and Start SHALL be ignored.
REQ-033 The count SHALL never go below 00:00 and SHALL never wrap to 99:59.
REQ-034 Tick SHALL be ignored outside RUN and RING.

Reset
REQ-035 Clr low SHALL, asynchronously, force state IDLE, all digits 0, the ring counter 0, and Running, Expired and Buzz 0.
REQ-036 Clr asserted mid-RUN or mid-RING SHALL abort with no Expired pulse.
REQ-037 After Clr is released, the block SHALL stay in IDLE until LD or Start.
REQ-038 The same reset values SHALL apply at power-up, before any Clr.

Structure
REQ-039 The shared package SHALL hold the state encoding constants (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, RING=2'b11) and the digit limit constants 9 and 5.
REQ-040 One sub-module, bcd_down_digit, SHALL be used: a single digit with parameter MAX, ports Clk, Clr, LD, IN, Dec (borrow-in), COUNT and Borrow, where Borrow is combinational and high when COUNT is 0 and Dec is high.
REQ-041 bcd_down_digit SHALL be instantiated four times, chained through Borrow; the FSM and ring counter SHALL live in countdown_timer.

Verification
REQ-042 The bench SHALL cover: Clr low, then LD with 01:00, Start, one Tick -> 00:59, Running=1.
REQ-043 The bench SHALL cover: load 00:02, Start, two Ticks -> Expired high for one Clk on the second, Buzz=1; with BUZZ_LEN=3, three more Ticks -> Buzz=0 and state IDLE.
REQ-044 The bench SHALL cover: load 10:00, Start, one Tick -> 09:59, showing the three-level borrow.
REQ-045 The bench SHALL cover: in RUN at 00:30, Stop and Tick in the same cycle -> 00:30 in PAUSE; then Start, Tick -> 00:29.
REQ-046 The bench SHALL cover: LD with IN_MT=12, IN_MU=15, IN_ST=7, IN_SU=10 -> 99:59; LD 00:00 then Start -> stays IDLE with Running=0.
REQ-047 The bench SHALL cover: Clr pulsed mid-RING -> Buzz=0 immediately (asynchronous), all digits 0, no Expired pulse.
